// File: rtl/throttle_pkg.sv
// Shared throttle-profile constants and player state encoding.
// Used by the profile player and the strategy/emission-model benches.
package throttle_pkg;

  localparam int STEPS    = 5;
  localparam int MAX_DIFF = 2;
  localparam int IDX_W    = $clog2(STEPS);
  localparam int CNT_W    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

endpackage

// File: rtl/throttle_diff_monitor.sv
// Counts accepted steps where the two replayed traces differ and
// raises a sticky flag once that count passes MAX_DIFF.
module throttle_diff_monitor
  import throttle_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic             throttle0,
  input  logic             throttle1,
  output logic [CNT_W-1:0] diff_cnt,
  output logic             diff_exceed
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_DIFF);

  logic             differ;
  logic [CNT_W-1:0] cnt_nxt;

  assign differ  = throttle0 ^ throttle1;
  // Saturate rather than wrap so a long replay never reads as clean.
  assign cnt_nxt = (diff_cnt == CNT_SAT) ? diff_cnt
                                         : diff_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_cnt    <= '0;
      diff_exceed <= 1'b0;
    end else if (clear) begin
      diff_cnt    <= '0;
      diff_exceed <= 1'b0;
    end else if (accept && differ) begin
      diff_cnt <= cnt_nxt;
      if (cnt_nxt > CNT_LIM) begin
        diff_exceed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/throttle_profile_player.sv
// Latches two throttle profiles and replays them one step per
// accepted handshake, tracking the per-step trace distance.
module throttle_profile_player
  import throttle_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [STEPS-1:0] profile0,
  input  logic [STEPS-1:0] profile1,
  input  logic             step_ready,
  output logic             throttle0,
  output logic             throttle1,
  output logic             thr_valid,
  output logic [IDX_W-1:0] step_idx,
  output logic [CNT_W-1:0] diff_cnt,
  output logic             diff_exceed,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEPS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [STEPS-1:0] prof0;
  logic [STEPS-1:0] prof1;
  logic [IDX_W-1:0] idx;
  logic             play;
  logic             start_acc;
  logic             accept;
  logic             last;

  assign play      = (state == PLAY);
  assign start_acc = (state == IDLE) && start;
  assign accept    = play && step_ready;
  assign last      = (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = PLAY;
      PLAY: if (accept && last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prof0 <= '0;
      prof1 <= '0;
      idx   <= '0;
    end else if (start_acc) begin
      prof0 <= profile0;
      prof1 <= profile1;
      idx   <= '0;
    end else if (accept) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

  // Outside PLAY the step outputs are forced to zero.
  assign thr_valid = play;
  assign busy      = play;
  assign done      = (state == DONE);
  assign throttle0 = play & prof0[idx];
  assign throttle1 = play & prof1[idx];
  assign step_idx  = play ? idx : '0;

  throttle_diff_monitor u_diff (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_acc),
    .accept      (accept),
    .throttle0   (throttle0),
    .throttle1   (throttle1),
    .diff_cnt    (diff_cnt),
    .diff_exceed (diff_exceed)
  );

endmodule

// File: tb/tb_throttle_profile_player.sv
// Scoreboard bench for throttle_profile_player: stimulus pushes the
// expected step stream, a negedge monitor pops and compares.
module tb_throttle_profile_player;
  import throttle_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [STEPS-1:0] profile0;
  logic [STEPS-1:0] profile1;
  logic             step_ready;
  logic             throttle0;
  logic             throttle1;
  logic             thr_valid;
  logic [IDX_W-1:0] step_idx;
  logic [CNT_W-1:0] diff_cnt;
  logic             diff_exceed;
  logic             busy;
  logic             done;

  throttle_profile_player dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .profile0    (profile0),
    .profile1    (profile1),
    .step_ready  (step_ready),
    .throttle0   (throttle0),
    .throttle1   (throttle1),
    .thr_valid   (thr_valid),
    .step_idx    (step_idx),
    .diff_cnt    (diff_cnt),
    .diff_exceed (diff_exceed),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int t0;
    int t1;
    int cnt;
    int exc;
  } step_t;

  step_t step_q[$];
  step_t done_q[$];
  int    checks    = 0;
  int    errors    = 0;
  int    done_seen = 0;
  int    exp_final = 0;
  int    exp_fexc  = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: step i shows bit i of each profile; the count shown
  // at step i is the number of differing bits below i.
  task automatic push_model(input logic [STEPS-1:0] p0,
                            input logic [STEPS-1:0] p1);
    int    cnt;
    step_t s;
    cnt = 0;
    for (int i = 0; i < STEPS; i++) begin
      s.idx = i;
      s.t0  = int'(p0[i]);
      s.t1  = int'(p1[i]);
      s.cnt = cnt;
      s.exc = (cnt > MAX_DIFF) ? 1 : 0;
      step_q.push_back(s);
      if (p0[i] != p1[i] && cnt < STEPS) cnt++;
    end
    s.idx = 0;
    s.t0  = 0;
    s.t1  = 0;
    s.cnt = cnt;
    s.exc = (cnt > MAX_DIFF) ? 1 : 0;
    done_q.push_back(s);
    exp_final = cnt;
    exp_fexc  = s.exc;
  endtask

  always @(negedge clk) begin
    step_t s;
    step_t d;
    if (rst_n) begin
      if (thr_valid) begin
        if (step_q.size() == 0) begin
          check("step_q_avail", step_q.size(), 1);
        end else begin
          s = step_q[0];
          check("step_idx", int'(step_idx), s.idx);
          check("throttle0", int'(throttle0), s.t0);
          check("throttle1", int'(throttle1), s.t1);
          check("diff_cnt", int'(diff_cnt), s.cnt);
          check("diff_exceed", int'(diff_exceed), s.exc);
          if (step_ready) void'(step_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          check("done_q_avail", done_q.size(), 1);
        end else begin
          d = done_q.pop_front();
          check("done_cnt", int'(diff_cnt), d.cnt);
          check("done_exc", int'(diff_exceed), d.exc);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_throttle0"}, int'(throttle0), 0);
    check({tag, "_throttle1"}, int'(throttle1), 0);
    check({tag, "_thr_valid"}, int'(thr_valid), 0);
    check({tag, "_step_idx"}, int'(step_idx), 0);
    check({tag, "_diff_cnt"}, int'(diff_cnt), 0);
    check({tag, "_diff_exceed"}, int'(diff_exceed), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic replay(input logic [STEPS-1:0] p0,
                        input logic [STEPS-1:0] p1,
                        input int stall_at, input int stall_len,
                        input int restart_at, input int rst_at,
                        input bit rnd_ready, input bit chk_lat);
    int lat;
    int stalled;
    int dbase;
    bit restarted;
    bit got;
    push_model(p0, p1);
    dbase = done_seen;
    @(posedge clk); #1;
    profile0   = p0;
    profile1   = p1;
    start      = 1'b1;
    step_ready = 1'b1;
    lat = 0;
    stalled = 0;
    restarted = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (rst_at >= 0 && thr_valid && int'(step_idx) == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        step_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_seen, dbase);
        check("abort_busy", int'(busy), 0);
        return;
      end
      if (restart_at >= 0 && !restarted && thr_valid &&
          int'(step_idx) == restart_at) begin
        start     = 1'b1;
        profile0  = ~p0;
        profile1  = STEPS'($urandom);
        restarted = 1'b1;
      end
      if (thr_valid && int'(step_idx) == stall_at &&
          stalled < stall_len) begin
        step_ready = 1'b0;
        if (stalled > 0) check("stall_idx", int'(step_idx), stall_at);
        stalled++;
      end else begin
        step_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", int'(got), 1);
    if (chk_lat) check("done_latency", lat, 6);
    repeat (2) @(posedge clk);
    #1;
    check("done_once", done_seen, dbase + 1);
    check("steps_left", step_q.size(), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(thr_valid), 0);
    check("idle_step_idx", int'(step_idx), 0);
    check("hold_cnt", int'(diff_cnt), exp_final);
    check("hold_exc", int'(diff_exceed), exp_fexc);
  endtask

  initial begin
    logic [STEPS-1:0] a;
    logic [STEPS-1:0] b;
    rst_n      = 1'b0;
    start      = 1'b1;
    profile0   = 5'b10101;
    profile1   = 5'b01110;
    step_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_valid", int'(thr_valid), 0);

    replay(5'b01010, 5'b10100, -1, 0, -1, -1, 1'b0, 1'b1);
    replay(5'b11011, 5'b11011, -1, 0, -1, -1, 1'b0, 1'b1);
    replay(5'b01010, 5'b10100, 2, 3, -1, -1, 1'b0, 1'b0);
    replay(5'b01010, 5'b10100, -1, 0, 1, -1, 1'b0, 1'b0);
    replay(5'b01010, 5'b10100, -1, 0, -1, 3, 1'b0, 1'b0);
    replay(5'b00111, 5'b10001, -1, 0, -1, -1, 1'b0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      a = STEPS'($urandom);
      b = STEPS'($urandom);
      replay(a, b,
             $urandom_range(4), $urandom_range(3),
             ($urandom_range(2) == 0) ? int'($urandom_range(4)) : -1,
             ($urandom_range(7) == 0) ? int'($urandom_range(4)) : -1,
             1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
